// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl
//   Byte-serialising controller in front of a byte-wide synchronous RAM.
//   Two clients share the RAM: instruction fetch (IF, 4-byte reads only) and
//   the load/store unit (LSU, 1/2/4-byte reads or writes).  Every request is
//   split into consecutive single-byte RAM accesses.  Read bytes are packed
//   little-endian and returned with a one-cycle done pulse.
//
//   Optional build macro: MEM_CTRL_ALIGN_CHECK_EN
//     defined   : misaligned LSU requests skip the RAM and complete at once
//                 with lsu_misalign_out pulsed alongside lsu_done_out.
//     undefined : lsu_misalign_out is tied low; misaligned requests proceed
//                 byte by byte like any other request.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   if_req_in / if_addr_in  IF read request (level) and byte address
//   if_done_out/if_data_out IF completion pulse and fetched word
//   lsu_req_in, lsu_wr_in, lsu_size_in, lsu_addr_in, lsu_wdata_in
//                           LSU request (level), direction, size, address, data
//   lsu_done_out, lsu_rdata_out, lsu_misalign_out
//                           LSU completion pulse, read data, misalign flag
//   ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out, ram_d_in
//                           byte RAM interface (read data one cycle after
//                           address, gated to zero by the RAM while en is low)

module mem_byte_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  lsu_req_in,
  input  logic                  lsu_wr_in,
  input  logic [1:0]            lsu_size_in,
  input  logic [31:0]           lsu_addr_in,
  input  logic [31:0]           lsu_wdata_in,
  output logic                  lsu_done_out,
  output logic [31:0]           lsu_rdata_out,
  output logic                  lsu_misalign_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic CLIENT_IF  = 1'b0;
  localparam logic CLIENT_LSU = 1'b1;

  // Architectural state
  state_t                  state_q,  state_d;
  logic [2:0]              cnt_q,    cnt_d;     // byte cycle index within access
  logic [2:0]              n_q,      n_d;       // byte count of current access
  logic [ADDR_WIDTH-1:0]   base_q,   base_d;
  logic [31:0]             wdata_q,  wdata_d;
  logic                    client_q, client_d;
  logic [31:0]             acc_q,    acc_d;     // read data being assembled

  // Registered outputs
  logic                    if_done_q,    if_done_d;
  logic [31:0]             if_data_q,    if_data_d;
  logic                    lsu_done_q,   lsu_done_d;
  logic [31:0]             lsu_rdata_q,  lsu_rdata_d;
  logic                    ram_en_q,     ram_en_d;
  logic                    ram_r_nw_q,   ram_r_nw_d;
  logic [ADDR_WIDTH-1:0]   ram_a_q,      ram_a_d;
  logic [7:0]              ram_d_q,      ram_d_d;

  logic [2:0]              lsu_nbytes;
  logic [1:0]              rd_byte_sel;
  logic [2:0]              addr_off;
  logic                    misal_d;

  // Upper request-address bits are discarded by design (truncation).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_in[31:ADDR_WIDTH], lsu_addr_in[31:ADDR_WIDTH]};

  always_comb begin
    case (lsu_size_in)
      2'b00:   lsu_nbytes = 3'd1;
      2'b01:   lsu_nbytes = 3'd2;
      default: lsu_nbytes = 3'd4;
    endcase
  end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  logic lsu_misaligned;
  logic misal_q;

  always_comb begin
    lsu_misaligned = ((lsu_size_in == 2'b01) && lsu_addr_in[0]) ||
                     (lsu_size_in[1] && (lsu_addr_in[1:0] != 2'b00));
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    client_d    = client_q;
    acc_d       = acc_q;
    if_data_d   = if_data_q;
    lsu_rdata_d = lsu_rdata_q;
    misal_d     = 1'b0;
    // Byte k arrives while cnt_q == k+1
    rd_byte_sel = cnt_q[1:0] - 2'd1;

    case (state_q)
      ST_IDLE: begin
        // LSU wins arbitration; IF is re-arbitrated on every IDLE visit.
        if (lsu_req_in) begin
          client_d = CLIENT_LSU;
          base_d   = lsu_addr_in[ADDR_WIDTH-1:0];
          n_d      = lsu_nbytes;
          wdata_d  = lsu_wdata_in;
          cnt_d    = 3'd0;
          acc_d    = 32'd0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
          if (lsu_misaligned) begin
            state_d = ST_DONE;
            misal_d = 1'b1;
          end else begin
            state_d = lsu_wr_in ? ST_WRITE : ST_READ;
          end
`else
          state_d = lsu_wr_in ? ST_WRITE : ST_READ;
`endif
        end else if (if_req_in) begin
          client_d = CLIENT_IF;
          base_d   = if_addr_in[ADDR_WIDTH-1:0];
          n_d      = 3'd4;
          cnt_d    = 3'd0;
          acc_d    = 32'd0;
          state_d  = ST_READ;
        end
      end

      ST_READ: begin
        if (cnt_q != 3'd0) begin
          acc_d[{rd_byte_sel, 3'b000} +: 8] = ram_d_in;
        end
        if (cnt_q == n_q) begin
          // Last byte has just been merged; publish to the owning client.
          state_d = ST_DONE;
          if (client_q == CLIENT_LSU) begin
            lsu_rdata_d = acc_d;
          end else begin
            if_data_d = acc_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_WRITE: begin
        if (cnt_q == n_q - 3'd1) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered: derive them from the state being entered so
    // they line up with that state's cycle.
    if_done_d  = (state_d == ST_DONE) && (client_d == CLIENT_IF);
    lsu_done_d = (state_d == ST_DONE) && (client_d == CLIENT_LSU);

    // The final read cycle repeats the last address so the RAM keeps
    // driving the last byte (its output is gated by en).
    addr_off = ((state_d == ST_READ) && (cnt_d == n_d)) ? (n_d - 3'd1) : cnt_d;

    ram_en_d   = 1'b0;
    ram_r_nw_d = 1'b1;
    ram_a_d    = ram_a_q;
    ram_d_d    = ram_d_q;
    case (state_d)
      ST_READ: begin
        ram_en_d = 1'b1;
        ram_a_d  = base_d + ADDR_WIDTH'(addr_off);
      end
      ST_WRITE: begin
        ram_en_d   = 1'b1;
        ram_r_nw_d = 1'b0;
        ram_a_d    = base_d + ADDR_WIDTH'(addr_off);
        ram_d_d    = wdata_d[{cnt_d[1:0], 3'b000} +: 8];
      end
      default: begin
        ram_en_d   = 1'b0;
        ram_r_nw_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      client_q    <= CLIENT_IF;
      acc_q       <= 32'd0;
      if_done_q   <= 1'b0;
      if_data_q   <= 32'd0;
      lsu_done_q  <= 1'b0;
      lsu_rdata_q <= 32'd0;
      ram_en_q    <= 1'b0;
      ram_r_nw_q  <= 1'b1;
      ram_a_q     <= '0;
      ram_d_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      client_q    <= client_d;
      acc_q       <= acc_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      lsu_done_q  <= lsu_done_d;
      lsu_rdata_q <= lsu_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_r_nw_q  <= ram_r_nw_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
    end
  end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      misal_q <= 1'b0;
    end else begin
      misal_q <= misal_d;
    end
  end

  assign lsu_misalign_out = misal_q;
`else
  logic unused_misal;
  assign unused_misal     = misal_d;
  assign lsu_misalign_out = 1'b0;
`endif

  assign if_done_out   = if_done_q;
  assign if_data_out   = if_data_q;
  assign lsu_done_out  = lsu_done_q;
  assign lsu_rdata_out = lsu_rdata_q;
  assign ram_en_out    = ram_en_q;
  assign ram_r_nw_out  = ram_r_nw_q;
  assign ram_a_out     = ram_a_q;
  assign ram_d_out     = ram_d_q;

endmodule
